dct_frame_sequencer: RTL and testbench

Time-multiplexed DCT engine and controller for the MFCC front end. It collects one frame of log-mel filterbank energies as a serial stream and buffers them. It then sequences a single multiply-accumulate unit through NUM_MFCC x NUM_FILTERS products, reading cosine coefficients from an external synchronous ROM. MFCCs are emitted serially with valid/ready backpressure. It sits between the log stage and the feature buffer.

---
 rtl/dct_frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_dct_frame_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_frame_sequencer.sv
// dct_frame_sequencer
// Time-multiplexed DCT for the MFCC front end. A frame of NUM_FILTERS signed
// log-mel energies is collected into a local buffer. One multiply-accumulate
// unit then computes NUM_MFCC dot products against cosine coefficients read
// from an external synchronous ROM. MFCCs leave serially under valid/ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   log_in/log_valid/...    serial log-energy input, log_ready high in LOAD only
//   coef_rd_en/coef_addr    ROM read strobe and address (k*NUM_FILTERS + n)
//   coef_data               ROM data, valid the cycle after coef_rd_en
//   mfcc_out/mfcc_idx       saturated MFCC value and its index k
//   mfcc_valid/mfcc_ready   output handshake, mfcc_last marks k = NUM_MFCC-1
//   busy                    high while a frame is being computed or emitted
//   frame_done              one-cycle pulse after the last MFCC is accepted
module dct_frame_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int COEF_FRAC   = 15,
  parameter int NUM_FILTERS = 26,
  parameter int NUM_MFCC    = 13,
  parameter int ACC_WIDTH   = 40,
  localparam int ADDR_WIDTH = (NUM_MFCC * NUM_FILTERS > 1) ? $clog2(NUM_MFCC * NUM_FILTERS) : 1,
  localparam int IDX_WIDTH  = (NUM_MFCC > 1) ? $clog2(NUM_MFCC) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] log_in,
  input  logic                         log_valid,
  output logic                         log_ready,
  output logic                         coef_rd_en,
  output logic [ADDR_WIDTH-1:0]        coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic signed [DATA_WIDTH-1:0] mfcc_out,
  output logic [IDX_WIDTH-1:0]         mfcc_idx,
  output logic                         mfcc_valid,
  input  logic                         mfcc_ready,
  output logic                         mfcc_last,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int N_WIDTH    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam logic [N_WIDTH-1:0]   N_LAST = N_WIDTH'(NUM_FILTERS - 1);
  localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(NUM_MFCC - 1);

  // DRAIN lets the final product land in the accumulator; ROUND then
  // shifts/saturates it into the output register.
  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ROUND = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  state_t                       state_r;
  logic [N_WIDTH-1:0]           n_r;
  logic [N_WIDTH-1:0]           mac_n_r;
  logic                         mac_en_r;
  logic [IDX_WIDTH-1:0]         k_r;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic signed [ACC_WIDTH-1:0]  acc_sum_s;
  logic signed [PROD_WIDTH-1:0] prod_s;
  logic                         sample_wr_s;
  logic signed [DATA_WIDTH-1:0] sample_buf_r [NUM_FILTERS];

  // Arithmetic shift (floor) by COEF_FRAC, then clamp to the output range.
  // The result fits only when every bit above the output sign bit equals it.
  function automatic logic signed [DATA_WIDTH-1:0] shift_saturate(
    input logic signed [ACC_WIDTH-1:0] acc
  );
    logic signed [ACC_WIDTH-1:0]   sh;
    logic [ACC_WIDTH-DATA_WIDTH:0] top;
    sh  = acc >>> COEF_FRAC;
    top = sh[ACC_WIDTH-1:DATA_WIDTH-1];
    if ((&top) || !(|top)) begin
      shift_saturate = sh[DATA_WIDTH-1:0];
    end else if (top[ACC_WIDTH-DATA_WIDTH]) begin
      shift_saturate = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      shift_saturate = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  endfunction

  assign log_ready   = (state_r == ST_LOAD);
  assign sample_wr_s = log_valid && (state_r == ST_LOAD);

  // Product of the buffered sample and the ROM word returned for it.
  always_comb begin
    prod_s    = sample_buf_r[mac_n_r] * coef_data;
    acc_sum_s = acc_r + ACC_WIDTH'(prod_s);
  end

  // Frame buffer: written only in LOAD, so it is stable for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
        sample_buf_r[i] <= '0;
      end
    end else if (sample_wr_s) begin
      sample_buf_r[n_r] <= log_in;
    end
  end

  // Sequencer FSM with registered outputs and the MAC datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_LOAD;
      n_r        <= '0;
      k_r        <= '0;
      mac_n_r    <= '0;
      mac_en_r   <= 1'b0;
      acc_r      <= '0;
      coef_rd_en <= 1'b0;
      coef_addr  <= '0;
      mfcc_out   <= '0;
      mfcc_idx   <= '0;
      mfcc_valid <= 1'b0;
      mfcc_last  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A read issued this cycle returns data next cycle; n_r tags it.
      mac_en_r   <= coef_rd_en;
      mac_n_r    <= n_r;
      if (mac_en_r) begin
        acc_r <= acc_sum_s;
      end
      case (state_r)
        ST_LOAD: begin
          if (log_valid) begin
            if (n_r == N_LAST) begin
              state_r    <= ST_ISSUE;
              n_r        <= '0;
              k_r        <= '0;
              acc_r      <= '0;
              coef_rd_en <= 1'b1;
              coef_addr  <= '0;
              busy       <= 1'b1;
            end else begin
              n_r <= n_r + N_WIDTH'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (n_r == N_LAST) begin
            state_r    <= ST_DRAIN;
            coef_rd_en <= 1'b0;
            n_r        <= '0;
          end else begin
            n_r       <= n_r + N_WIDTH'(1);
            coef_addr <= coef_addr + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          state_r <= ST_ROUND;
        end
        ST_ROUND: begin
          mfcc_out   <= shift_saturate(acc_r);
          mfcc_idx   <= k_r;
          mfcc_valid <= 1'b1;
          mfcc_last  <= (k_r == K_LAST);
          state_r    <= ST_EMIT;
        end
        ST_EMIT: begin
          if (mfcc_ready) begin
            mfcc_valid <= 1'b0;
            mfcc_last  <= 1'b0;
            n_r        <= '0;
            if (k_r != K_LAST) begin
              // Addresses run contiguously, so the next row starts one past the last read.
              k_r        <= k_r + IDX_WIDTH'(1);
              acc_r      <= '0;
              coef_rd_en <= 1'b1;
              coef_addr  <= coef_addr + ADDR_WIDTH'(1);
              state_r    <= ST_ISSUE;
            end else begin
              k_r        <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state_r    <= ST_LOAD;
            end
          end
        end
        default: begin
          state_r    <= ST_LOAD;
          n_r        <= '0;
          k_r        <= '0;
          coef_rd_en <= 1'b0;
          mfcc_valid <= 1'b0;
          mfcc_last  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_frame_sequencer.sv
// Scoreboard bench for dct_frame_sequencer: accepted samples feed a reference
// model whose results are queued and compared as MFCCs are handed off.
module tb_dct_frame_sequencer;

  localparam int NF = 26;
  localparam int NM = 13;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] log_in;
  logic               log_valid;
  logic               log_ready;
  logic               coef_rd_en;
  logic [8:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic signed [15:0] mfcc_out;
  logic [3:0]         mfcc_idx;
  logic               mfcc_valid;
  logic               mfcc_ready;
  logic               mfcc_last;
  logic               busy;
  logic               frame_done;

  dct_frame_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .log_in     (log_in),
    .log_valid  (log_valid),
    .log_ready  (log_ready),
    .coef_rd_en (coef_rd_en),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .mfcc_out   (mfcc_out),
    .mfcc_idx   (mfcc_idx),
    .mfcc_valid (mfcc_valid),
    .mfcc_ready (mfcc_ready),
    .mfcc_last  (mfcc_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    int     idx;
    bit     last;
  } exp_t;

  exp_t               exp_q[$];
  int                 checks = 0;
  int                 failures = 0;
  int                 cyc = 0;
  int                 rom_mode = 0;
  int                 coef_const = 0;
  logic signed [15:0] frame_buf [NF];
  logic signed [15:0] samp [NF];
  int                 ns = 0;
  int                 fd_count = 0;
  int                 exp_addr = 0;
  int                 run_len = 0;
  bit                 rd_q = 1'b0;
  int                 addr_q = 0;
  bit                 in_flight = 1'b0;
  bit                 fd_expect = 1'b0;
  bit                 wait_valid = 1'b0;
  int                 ev_edge = 0;
  int                 flush_req = 0;
  int                 flush_seen = 0;
  bit                 bp_enable = 1'b0;
  bit                 bp_hold = 1'b0;
  bit                 bp_done = 1'b0;
  int                 bp_cnt = 0;

  task automatic check_value(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic signed [15:0] rom_val(input int a);
    int v;
    if (rom_mode == 0) v = coef_const;
    else v = ((a * 97 + 13) % 4001) - 2000;
    return 16'(v);
  endfunction

  function automatic longint model_mfcc(input int k);
    longint sum;
    sum = 0;
    for (int n = 0; n < NF; n++) sum += longint'(samp[n]) * longint'(rom_val(k * NF + n));
    sum = sum >>> 15;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  // Edge counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous ROM model: data for a read appears the cycle after the strobe.
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_q) coef_data = rom_val(addr_q);
    else coef_data = 16'($urandom);
  end

  // Downstream ready driver.
  initial forever begin
    @(posedge clk);
    #1;
    mfcc_ready = !bp_hold;
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (flush_req != flush_seen) begin
      flush_seen = flush_req;
      exp_q.delete();
      ns = 0; in_flight = 0; fd_expect = 0; wait_valid = 0;
      exp_addr = 0; run_len = 0; rd_q = 0; bp_hold = 0; bp_cnt = 0;
    end
    if (!bp_enable) begin
      bp_done = 0;
      bp_cnt = 0;
    end
    if (rst_n) begin
      check_value("frame_done", frame_done, fd_expect);
      fd_expect = 0;
      if (frame_done) begin
        fd_count++;
        in_flight = 0;
      end
      check_value("busy", busy, in_flight);
      if (in_flight) check_value("log_ready_busy", log_ready, 0);
      if (coef_rd_en) begin
        check_value("coef_addr", coef_addr, exp_addr);
        exp_addr++;
        run_len++;
      end else if (run_len != 0) begin
        check_value("rd_run_len", run_len, NF);
        run_len = 0;
      end
      rd_q = coef_rd_en;
      addr_q = int'(coef_addr);
      if (mfcc_valid) begin
        check_value("rd_during_emit", coef_rd_en, 0);
        if (exp_q.size() == 0) begin
          check_value("stray_valid", mfcc_valid, 0);
        end else begin
          exp_t e;
          e = exp_q[0];
          if (wait_valid) begin
            check_value("valid_latency", cyc - ev_edge, NF + 2);
            wait_valid = 0;
          end
          check_value("mfcc_out", mfcc_out, e.val);
          check_value("mfcc_idx", mfcc_idx, e.idx);
          check_value("mfcc_last", mfcc_last, e.last);
          if (mfcc_ready) begin
            void'(exp_q.pop_front());
            if (e.last) begin
              fd_expect = 1;
            end else begin
              ev_edge = cyc + 1;
              wait_valid = 1;
            end
            if (bp_enable && !bp_done && e.idx == 2) bp_hold = 1;
          end else if (bp_hold) begin
            bp_cnt++;
            if (bp_cnt == 5) begin
              bp_hold = 0;
              bp_done = 1;
            end
          end
        end
      end
      if (log_valid && log_ready) begin
        samp[ns] = log_in;
        ns++;
        if (ns == NF) begin
          for (int k = 0; k < NM; k++) begin
            exp_t e;
            e.val = model_mfcc(k);
            e.idx = k;
            e.last = (k == NM - 1);
            exp_q.push_back(e);
          end
          ns = 0;
          in_flight = 1;
          ev_edge = cyc + 1;
          wait_valid = 1;
          exp_addr = 0;
        end
      end
    end
  end

  task automatic drive_frame(input bit gaps, input bit keep_valid);
    for (int i = 0; i < NF; i++) begin
      int t;
      if (gaps && $urandom_range(0, 2) == 0) begin
        log_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      log_in = frame_buf[i];
      log_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!log_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (!log_ready) check_value("accept_timeout", log_ready, 1);
      @(posedge clk);
      #1;
    end
    if (!keep_valid) log_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (fd_count < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (fd_count < target) check_value("frame_timeout", fd_count, target);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NF; i++) frame_buf[i] = 16'(v);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NF; i++) frame_buf[i] = 16'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_mfcc_out"}, mfcc_out, 0);
    check_value({tag, "_mfcc_idx"}, mfcc_idx, 0);
    check_value({tag, "_mfcc_valid"}, mfcc_valid, 0);
    check_value({tag, "_mfcc_last"}, mfcc_last, 0);
    check_value({tag, "_coef_rd_en"}, coef_rd_en, 0);
    check_value({tag, "_coef_addr"}, coef_addr, 0);
    check_value({tag, "_frame_done"}, frame_done, 0);
    check_value({tag, "_busy"}, busy, 0);
    check_value({tag, "_log_ready"}, log_ready, 1);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    log_valid = 1'b0;
    log_in = '0;
    mfcc_ready = 1'b1;
    coef_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant frame: 1000 * 0.5 * 26 = 13000 on every coefficient.
    rom_mode = 0; coef_const = 16384;
    fill_const(1000);
    drive_frame(1'b1, 1'b0);
    wait_frames(1);

    // Address-dependent ROM with random samples.
    rom_mode = 1;
    fill_random();
    drive_frame(1'b1, 1'b0);
    wait_frames(2);

    // Saturation high, saturation low, and floor behaviour of the shift.
    rom_mode = 0; coef_const = 32767;
    fill_const(32767);
    drive_frame(1'b0, 1'b0);
    wait_frames(3);
    fill_const(-32768);
    drive_frame(1'b0, 1'b0);
    wait_frames(4);
    coef_const = 1;
    fill_const(0);
    frame_buf[7] = -16'sd1;
    drive_frame(1'b0, 1'b0);
    wait_frames(5);

    // Backpressure at k=3.
    rom_mode = 1;
    bp_enable = 1'b1;
    fill_random();
    drive_frame(1'b1, 1'b0);
    wait_frames(6);
    check_value("bp_applied", bp_done, 1);
    bp_enable = 1'b0;

    // log_valid held high across the compute of one frame into the next.
    fill_random();
    drive_frame(1'b0, 1'b1);
    fill_random();
    drive_frame(1'b0, 1'b0);
    wait_frames(8);

    // Reset in the middle of the k=5 ROM sweep.
    rom_mode = 0; coef_const = 16384;
    fill_const(1000);
    drive_frame(1'b0, 1'b0);
    t = 0;
    while (exp_addr < 5 * NF + 4 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_addr < 5 * NF + 4) check_value("reach_k5_timeout", exp_addr, 5 * NF + 4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    flush_req++;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset_hold");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_value("post_reset_log_ready", log_ready, 1);
    @(posedge clk);
    #1;
    drive_frame(1'b1, 1'b0);
    wait_frames(9);

    repeat (5) @(negedge clk);
    check_value("frame_done_count", fd_count, 9);
    check_value("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
